instr_fetch_unit: RTL and testbench

Fetch stage of the WISC-F15 pipeline. Owns the program counter, drives address and read enable into the instruction memory (which latches on clock low, so data for an address issued in cycle n is stable at the rising edge ending cycle n), and buffers fetched words in a 2-entry queue. Presents them to decode through a valid/ready handshake. Handles branch redirects and the halt instruction.

---
 rtl/wisc_fetch_pkg.sv | 12 +
 rtl/fetch_queue.sv | 51 +++++
 rtl/instr_fetch_unit.sv | 71 +++++++
 tb/tb_instr_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_fetch_pkg.sv
// rtl/wisc_fetch_pkg.sv - shared defaults and queue entry type for the WISC-F15 fetch stage
package wisc_fetch_pkg;

    localparam logic [15:0] RESET_PC_DEFAULT   = 16'h0000;
    localparam logic [3:0]  HLT_OPCODE_DEFAULT = 4'hF;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_plus1;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - two-entry synchronous FIFO of fetched words with flush
module fetch_queue
    import wisc_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_push_entry,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;

    // Push into a full queue is only legal together with a pop; the caller guarantees that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - WISC-F15 fetch stage: PC, halt flag, issue logic and output queue
module instr_fetch_unit
    import wisc_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [3:0]  HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] im_addr,
    output logic        im_rd_en,
    input  logic [15:0] im_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc_plus1,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        halted
);

    logic [15:0]  r_pc;
    logic         r_halted;
    logic [1:0]   w_count;
    logic         w_pop;
    logic         w_issue;
    logic [15:0]  w_pc_plus1;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    assign w_pc_plus1   = r_pc + 16'd1;
    assign out_valid    = (w_count != 2'd0);
    assign w_pop        = out_valid & out_ready;
    // A slot frees up in the same cycle as a pop, so a full queue can still accept a word.
    assign w_issue      = ~rst & ~r_halted & ~redirect & ((w_count != 2'd2) | w_pop);
    assign w_push_entry = '{instr: im_instr, pc_plus1: w_pc_plus1};

    fetch_queue u_queue (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_issue),
        .i_pop        (w_pop),
        .i_flush      (redirect),
        .i_push_entry (w_push_entry),
        .o_head       (w_head),
        .o_count      (w_count)
    );

    // Redirect wins over issue and also discards any halt seen on the wrong path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
        end else if (redirect) begin
            r_pc     <= redirect_pc;
            r_halted <= 1'b0;
        end else if (w_issue) begin
            r_pc <= w_pc_plus1;
            if (im_instr[15:12] == HLT_OPCODE) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign im_addr      = r_pc;
    assign im_rd_en     = w_issue;
    assign out_instr    = w_head.instr;
    assign out_pc_plus1 = w_head.pc_plus1;
    assign halted       = r_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit against an address-stream model
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [15:0] im_instr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc_plus1;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;

    logic [15:0] mem [0:65535];

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pcp1;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    assign im_instr = mem[im_addr];

    instr_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .im_addr      (im_addr),
        .im_rd_en     (im_rd_en),
        .im_instr     (im_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc_plus1 (out_pc_plus1),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halted       (halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Program-order model: delivered words are consecutive addresses from the start point up to and including a halt.
    function automatic void seg_start(input logic [15:0] start);
        logic [15:0] a;
        exp_t        e;
        a = start;
        exp_q.delete();
        for (int k = 0; k < 256; k++) begin
            e.instr = mem[a];
            e.pcp1  = a + 16'd1;
            exp_q.push_back(e);
            if (e.instr[15:12] == 4'hF) break;
            a = a + 16'd1;
        end
    endfunction

    task automatic do_redirect(input logic [15:0] a);
        redirect    = 1'b1;
        redirect_pc = a;
        seg_start(a);
        @(posedge clk);
        #1;
        redirect = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic        p_hold = 1'b0;
    logic [15:0] p_instr;
    logic [15:0] p_pcp1;

    always @(negedge clk) begin
        if (rst) begin
            p_hold = 1'b0;
        end else begin
            if (p_hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_instr", 32'(out_instr), 32'(p_instr));
                chk("hold_pc_plus1", 32'(out_pc_plus1), 32'(p_pcp1));
            end
            if (out_valid && out_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_output: got instr %h pc_plus1 %h, expected no word", out_instr, out_pc_plus1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_instr", 32'(out_instr), 32'(mon_e.instr));
                    chk("out_pc_plus1", 32'(out_pc_plus1), 32'(mon_e.pcp1));
                end
            end
            p_hold  = out_valid && !out_ready && !redirect;
            p_instr = out_instr;
            p_pcp1  = out_pc_plus1;
        end
    end

    initial begin
        int          issued5;
        int          since;
        logic [15:0] ra;

        rst         = 1'b1;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 + 16'(i);

        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_im_rd_en", 32'(im_rd_en), 32'd0);
        chk("rst_im_addr", 32'(im_addr), 32'h0000);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_out_instr", 32'(out_instr), 32'h0000);
        chk("rst_out_pc_plus1", 32'(out_pc_plus1), 32'h0000);

        // Streaming with decode always ready
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        seg_start(16'h0000);
        @(negedge clk);
        chk("first_issue_en", 32'(im_rd_en), 32'd1);
        chk("first_issue_addr", 32'(im_addr), 32'h0000);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("stream_valid", 32'(out_valid), 32'd1);
        end

        // Back-pressure fills the queue and freezes the PC
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("stall_rd_en", 32'(im_rd_en), 32'd0);
        chk("stall_valid", 32'(out_valid), 32'd1);
        if (exp_q.size() > 0) chk("stall_pc_ahead", 32'(im_addr), 32'(exp_q[0].pcp1 + 16'd1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cycles(5);

        // Redirect while the queue is full
        out_ready = 1'b0;
        cycles(3);
        out_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        seg_start(16'h0040);
        @(negedge clk);
        chk("redir_full_valid", 32'(out_valid), 32'd1);
        chk("redir_no_issue", 32'(im_rd_en), 32'd0);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("redir_addr", 32'(im_addr), 32'h0040);
        chk("redir_flushed", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("redir_first_valid", 32'(out_valid), 32'd1);
        cycles(4);

        // Halt at address 5
        mem[5] = 16'hF000;
        do_redirect(16'h0000);
        issued5 = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (issued5 >= 0 && c == issued5 + 1) chk("halt_timing", 32'(halted), 32'd1);
            if (im_rd_en && im_addr == 16'h0005) issued5 = c;
        end
        chk("halt_issue_seen", 32'(issued5 >= 0), 32'd1);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_rd_en", 32'(im_rd_en), 32'd0);
        chk("halt_pc", 32'(im_addr), 32'h0006);
        chk("halt_drained", 32'(out_valid), 32'd0);
        chk("halt_all_delivered", 32'(exp_q.size()), 32'd0);

        // Redirect out of a (wrong-path) halt
        @(posedge clk);
        #1;
        do_redirect(16'h0010);
        @(negedge clk);
        chk("unhalt_flag", 32'(halted), 32'd0);
        chk("unhalt_addr", 32'(im_addr), 32'h0010);
        chk("unhalt_rd_en", 32'(im_rd_en), 32'd1);
        cycles(6);

        // PC wrap: FFFF then 0..5 (5 halts)
        do_redirect(16'hFFFF);
        cycles(12);
        chk("wrap_all_delivered", 32'(exp_q.size()), 32'd0);
        chk("wrap_halted", 32'(halted), 32'd1);

        // Asynchronous reset in mid-stream
        do_redirect(16'h0100);
        cycles(3);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_rd_en", 32'(im_rd_en), 32'd0);
        chk("midrst_pc", 32'(im_addr), 32'h0000);
        chk("midrst_halted", 32'(halted), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seg_start(16'h0000);
        cycles(10);
        chk("midrst_rehalt", 32'(halted), 32'd1);

        // Randomised traffic over random memory contents
        for (int i = 0; i < 65536; i++) begin
            mem[i] = {($urandom_range(15) == 0) ? 4'hF : 4'($urandom_range(14)), 12'($urandom)};
        end
        do_redirect(16'($urandom));
        since = 0;
        for (int c = 0; c < 1500; c++) begin
            out_ready = ($urandom_range(3) != 0);
            since++;
            if ($urandom_range(15) == 0 || since >= 200) begin
                ra = ($urandom_range(3) == 0) ? (16'hFFF0 + 16'($urandom_range(15))) : 16'($urandom);
                redirect    = 1'b1;
                redirect_pc = ra;
                seg_start(ra);
                since = 0;
            end else begin
                redirect = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        redirect  = 1'b0;
        out_ready = 1'b1;
        cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
